// File: rtl/vscale_fetch_queue_pkg.sv
// Shared constants for the vscale decoupled fetch unit.
// Widths, the canonical NOP and the fetch-entry layout.
package vscale_fetch_queue_pkg;

   localparam int          FQ_XPR_LEN    = 32;
   localparam int          FQ_INST_WIDTH = 32;
   localparam logic [31:0] RV_NOP        = 32'h0000_0013;
   localparam logic [31:0] FQ_RESET_PC   = 32'h0000_0200;

   // Entry = {inst, pc, badmem}
   localparam int FQ_ENTRY_W = FQ_INST_WIDTH + FQ_XPR_LEN + 1;

   function automatic int fq_entry_w(input int xlen);
      return FQ_INST_WIDTH + xlen + 1;
   endfunction

endpackage

// File: rtl/vscale_sync_fifo.sv
// Synchronous power-of-two FIFO with flush.
// Flush wins over push and pop; no read bypass.
module vscale_sync_fifo #(
   parameter  int WIDTH = 65,
   parameter  int DEPTH = 4,
   localparam int AW    = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             push,
   input  logic [WIDTH-1:0] wdata,
   input  logic             pop,
   input  logic             flush,
   output logic [WIDTH-1:0] rdata,
   output logic             full,
   output logic             empty,
   output logic [AW:0]      count
);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [AW:0]      count_q, count_d;
   logic             do_push, do_pop;

   assign full    = (count_q == (AW+1)'(DEPTH));
   assign empty   = (count_q == '0);
   assign count   = count_q;
   assign rdata   = mem_q[rd_ptr_q];
   assign do_push = push & ~full & ~flush;
   assign do_pop  = pop & ~empty & ~flush;

   // Pointer and occupancy next-state; flush clears everything.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
         if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
         unique case ({do_push, do_pop})
            2'b10:   count_d = count_q + (AW+1)'(1);
            2'b01:   count_d = count_q - (AW+1)'(1);
            default: count_d = count_q;
         endcase
      end
   end

   // Control state register.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Entry storage; contents are only observed while non-empty.
   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q] <= wdata;
   end

endmodule

// File: rtl/vscale_fetch_queue.sv
// Decoupled prefetching IF stage for vscale.
// Owns the fetch PC and buffers fetched words for decode.
module vscale_fetch_queue
   import vscale_fetch_queue_pkg::*;
#(
   parameter int                 XPR_LEN  = FQ_XPR_LEN,
   parameter int                 DEPTH    = 4,
   parameter logic [XPR_LEN-1:0] RESET_PC = XPR_LEN'(FQ_RESET_PC)
) (
   input  logic                     clk,
   input  logic                     reset_n,
   output logic                     imem_req_valid,
   output logic [XPR_LEN-1:0]       imem_addr,
   input  logic                     imem_wait,
   input  logic [FQ_INST_WIDTH-1:0] imem_rdata,
   input  logic                     imem_badmem_e,
   input  logic                     redirect_valid,
   input  logic [XPR_LEN-1:0]       redirect_pc,
   output logic                     inst_valid,
   input  logic                     inst_ready,
   output logic [FQ_INST_WIDTH-1:0] inst,
   output logic [XPR_LEN-1:0]       inst_pc,
   output logic                     inst_badmem
);

   localparam int AW = $clog2(DEPTH);
   localparam int EW = fq_entry_w(XPR_LEN);

   logic [XPR_LEN-1:0]       fetch_pc_q, fetch_pc_d;
   logic [XPR_LEN-1:0]       req_pc_q, req_pc_d;
   logic                     inflight_q, inflight_d;
   logic                     drop_q, drop_d;
   logic                     accept, resp_done, credit;
   logic [AW:0]              count;
   logic [AW+1:0]            occupancy;
   logic                     push, pop, full, empty;
   logic [EW-1:0]            wdata, rdata;
   logic [FQ_INST_WIDTH-1:0] resp_inst;

   // Credits count queued entries plus the one in flight,
   // so a response always finds a free slot.
   assign occupancy = {1'b0, count}
                    + {{(AW+1){1'b0}}, inflight_q};
   assign credit    = occupancy < (AW+2)'(DEPTH);

   // A redirect flushes the queue, so it never needs credit.
   assign imem_req_valid = credit | redirect_valid;
   assign imem_addr      = redirect_valid ? redirect_pc
                                          : fetch_pc_q;

   assign accept    = imem_req_valid & ~imem_wait;
   assign resp_done = inflight_q & ~imem_wait;

   // Faulting fetches enqueue a NOP tagged as bad.
   assign resp_inst = imem_badmem_e ? RV_NOP : imem_rdata;
   assign wdata     = {resp_inst, req_pc_q, imem_badmem_e};

   assign push = resp_done & ~drop_q & ~redirect_valid
               & ~full;
   assign pop  = inst_valid & inst_ready & ~redirect_valid;

   vscale_sync_fifo #(
      .WIDTH (EW),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk     (clk),
      .reset_n (reset_n),
      .push    (push),
      .wdata   (wdata),
      .pop     (pop),
      .flush   (redirect_valid),
      .rdata   (rdata),
      .full    (full),
      .empty   (empty),
      .count   (count)
   );

   // Head outputs read as a NOP at PC 0 while the queue is empty.
   assign inst_valid  = ~empty;
   assign inst        = inst_valid
                      ? rdata[EW-1 -: FQ_INST_WIDTH] : RV_NOP;
   assign inst_pc     = inst_valid ? rdata[XPR_LEN:1] : '0;
   assign inst_badmem = inst_valid & rdata[0];

   // Next fetch PC and in-flight/drop tracking.
   always_comb begin
      fetch_pc_d = fetch_pc_q;
      req_pc_d   = req_pc_q;
      inflight_d = inflight_q;
      drop_d     = drop_q;
      if (accept) begin
         fetch_pc_d = imem_addr + XPR_LEN'(4);
         req_pc_d   = imem_addr;
         inflight_d = 1'b1;
         drop_d     = 1'b0;
      end else begin
         if (redirect_valid) fetch_pc_d = redirect_pc;
         if (resp_done) begin
            inflight_d = 1'b0;
            drop_d     = 1'b0;
         end else if (redirect_valid & inflight_q) begin
            // Waited data phase: discard it once it ends.
            drop_d = 1'b1;
         end
      end
   end

   // Fetch-engine state register.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         fetch_pc_q <= RESET_PC;
         req_pc_q   <= '0;
         inflight_q <= 1'b0;
         drop_q     <= 1'b0;
      end else begin
         fetch_pc_q <= fetch_pc_d;
         req_pc_q   <= req_pc_d;
         inflight_q <= inflight_d;
         drop_q     <= drop_d;
      end
   end

endmodule

// File: tb/tb_vscale_fetch_queue.sv
// Self-checking bench for vscale_fetch_queue.
// Queue-level reference model plus directed scenarios.
module tb_vscale_fetch_queue;

   localparam int          DEPTH = 4;
   localparam logic [31:0] NOP   = 32'h0000_0013;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        imem_req_valid;
   logic [31:0] imem_addr;
   logic        imem_wait;
   logic [31:0] imem_rdata;
   logic        imem_badmem_e;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        inst_valid;
   logic        inst_ready;
   logic [31:0] inst;
   logic [31:0] inst_pc;
   logic        inst_badmem;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   vscale_fetch_queue #(
      .XPR_LEN  (32),
      .DEPTH    (DEPTH),
      .RESET_PC (32'h200)
   ) dut (
      .clk            (clk),
      .reset_n        (reset_n),
      .imem_req_valid (imem_req_valid),
      .imem_addr      (imem_addr),
      .imem_wait      (imem_wait),
      .imem_rdata     (imem_rdata),
      .imem_badmem_e  (imem_badmem_e),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .inst_valid     (inst_valid),
      .inst_ready     (inst_ready),
      .inst           (inst),
      .inst_pc        (inst_pc),
      .inst_badmem    (inst_badmem)
   );

   task automatic check(input string nm,
                        input logic [31:0] act,
                        input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   // Memory contents: a simple address-derived pattern.
   function automatic logic [31:0] word(input logic [31:0] a);
      return {~a[15:0], a[15:0]};
   endfunction

   // Memory responder: remembers the address in its data phase.
   logic [31:0] dp_addr;
   logic [31:0] bad_addr;

   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) dp_addr <= 32'h0;
      else if (imem_req_valid && !imem_wait) dp_addr <= imem_addr;
   end

   assign imem_rdata    = word(dp_addr);
   assign imem_badmem_e = (dp_addr == bad_addr);

   typedef struct {
      logic [31:0] pc;
      logic [31:0] inst;
      logic        bad;
   } ent_t;

   // Observation logs used by the directed checks.
   logic [31:0] acc_log[$];
   ent_t        pop_log[$];
   int          cyc, first_acc, first_iv;

   always @(posedge clk) begin
      if (reset_n) begin
         cyc++;
         if (imem_req_valid && !imem_wait) begin
            acc_log.push_back(imem_addr);
            if (first_acc < 0) first_acc = cyc;
         end
         if (inst_valid && inst_ready && !redirect_valid)
            pop_log.push_back('{inst_pc, inst, inst_badmem});
         if (first_iv < 0 && inst_valid) first_iv = cyc;
      end
   end

   // Reference model: a queue of expected entries, the
   // outstanding request and the next sequential address.
   ent_t        mq[$];
   logic        m_inf, m_drop;
   logic [31:0] m_ipc, m_pc;

   function automatic ent_t mk(input logic [31:0] pc);
      ent_t e;
      e.pc   = pc;
      e.bad  = (pc == bad_addr);
      e.inst = e.bad ? NOP : word(pc);
      return e;
   endfunction

   always @(negedge clk) begin
      logic        e_req, e_iv, acc, done;
      logic [31:0] e_addr;
      if (!reset_n) begin
         check("rst_req_valid", 32'(imem_req_valid), 32'd1);
         check("rst_addr", imem_addr, 32'h200);
         check("rst_inst_valid", 32'(inst_valid), 32'd0);
         check("rst_inst", inst, NOP);
         check("rst_inst_pc", inst_pc, 32'h0);
         check("rst_badmem", 32'(inst_badmem), 32'd0);
         mq.delete();
         m_inf  = 1'b0;
         m_drop = 1'b0;
         m_ipc  = 32'h0;
         m_pc   = 32'h200;
      end else begin
         e_req  = ((mq.size() + (m_inf ? 1 : 0)) < DEPTH)
                || redirect_valid;
         e_addr = redirect_valid ? redirect_pc : m_pc;
         e_iv   = (mq.size() > 0);
         check("req_valid", 32'(imem_req_valid), 32'(e_req));
         check("imem_addr", imem_addr, e_addr);
         check("inst_valid", 32'(inst_valid), 32'(e_iv));
         if (e_iv) begin
            check("inst", inst, mq[0].inst);
            check("inst_pc", inst_pc, mq[0].pc);
            check("inst_badmem", 32'(inst_badmem),
                  32'(mq[0].bad));
         end
         acc  = e_req && !imem_wait;
         done = m_inf && !imem_wait;
         if (redirect_valid) begin
            mq.delete();
         end else begin
            if (e_iv && inst_ready) void'(mq.pop_front());
            if (done && !m_drop) mq.push_back(mk(m_ipc));
         end
         if (redirect_valid && m_inf && !done) m_drop = 1'b1;
         if (done) begin
            m_inf  = 1'b0;
            m_drop = 1'b0;
         end
         if (acc) begin
            m_inf  = 1'b1;
            m_drop = 1'b0;
            m_ipc  = e_addr;
            m_pc   = e_addr + 32'd4;
         end else if (redirect_valid) begin
            m_pc = redirect_pc;
         end
      end
   end

   function automatic logic [31:0] acc_at(input int i);
      if (i < acc_log.size()) return acc_log[i];
      return 32'hDEAD_BEEF;
   endfunction

   function automatic logic [31:0] pop_pc_at(input int i);
      if (i < pop_log.size()) return pop_log[i].pc;
      return 32'hDEAD_BEEF;
   endfunction

   function automatic int find_pop(input logic [31:0] pc);
      foreach (pop_log[i]) if (pop_log[i].pc == pc) return i;
      return -1;
   endfunction

   function automatic int count_pop(input logic [31:0] pc);
      int n = 0;
      foreach (pop_log[i]) if (pop_log[i].pc == pc) n++;
      return n;
   endfunction

   task automatic run(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Hold reset two edges, then release just after an edge.
   task automatic do_reset(input logic rdy);
      reset_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      acc_log.delete();
      pop_log.delete();
      cyc            = 0;
      first_acc      = -1;
      first_iv       = -1;
      inst_ready     = rdy;
      imem_wait      = 1'b0;
      redirect_valid = 1'b0;
      reset_n        = 1'b1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   initial begin
      int idx, n;
      inst_ready     = 1'b0;
      imem_wait      = 1'b0;
      redirect_valid = 1'b0;
      redirect_pc    = 32'h0;
      bad_addr       = 32'hFFFF_FFFF;
      first_acc      = -1;
      first_iv       = -1;
      cyc            = 0;

      // Streaming after reset with decode always ready.
      do_reset(1'b1);
      run(8);
      check("t1_acc0", acc_at(0), 32'h200);
      check("t1_acc1", acc_at(1), 32'h204);
      check("t1_acc2", acc_at(2), 32'h208);
      check("t1_pop0", pop_pc_at(0), 32'h200);
      check("t1_pop1", pop_pc_at(1), 32'h204);
      check("t1_latency", 32'(first_iv - first_acc), 32'd2);

      // Queue fills, request stalls, one pop restarts it.
      do_reset(1'b0);
      run(8);
      check("t2_acc_n", 32'(acc_log.size()), 32'd4);
      check("t2_req_off", 32'(imem_req_valid), 32'd0);
      check("t2_addr_hold", imem_addr, 32'h210);
      inst_ready = 1'b1;
      run(1);
      inst_ready = 1'b0;
      check("t2_acc_n_pop", 32'(acc_log.size()), 32'd4);
      check("t2_req_on", 32'(imem_req_valid), 32'd1);
      run(1);
      check("t2_acc_n_after", 32'(acc_log.size()), 32'd5);
      check("t2_acc4", acc_at(4), 32'h210);
      check("t2_pop0", pop_pc_at(0), 32'h200);

      // Wait states in the data phase of 0x204.
      do_reset(1'b1);
      n = 0;
      do begin
         run(1);
         n++;
      end while (dp_addr != 32'h204 && n < 10);
      check("t3_reach_dp", dp_addr, 32'h204);
      imem_wait = 1'b1;
      repeat (3) begin
         check("t3_addr_hold", imem_addr, 32'h208);
         run(1);
         check("t3_no_write", 32'(count_pop(32'h204)), 32'd0);
      end
      imem_wait = 1'b0;
      run(4);
      check("t3_once", 32'(count_pop(32'h204)), 32'd1);
      idx = find_pop(32'h204);
      if (idx >= 0)
         check("t3_data", pop_log[idx].inst, 32'hFDFB_0204);

      // Redirect with 0x20C in flight and three queued.
      do_reset(1'b0);
      n = 0;
      while (acc_log.size() < 4 && n < 10) begin
         run(1);
         n++;
      end
      check("t4_setup", 32'(acc_log.size()), 32'd4);
      check("t4_pre_valid", 32'(inst_valid), 32'd1);
      redirect_valid = 1'b1;
      redirect_pc    = 32'h400;
      inst_ready     = 1'b1;
      #1;
      check("t4_redir_addr", imem_addr, 32'h400);
      run(1);
      redirect_valid = 1'b0;
      check("t4_flushed", 32'(inst_valid), 32'd0);
      check("t4_no_pop", 32'(pop_log.size()), 32'd0);
      run(6);
      check("t4_pop0", pop_pc_at(0), 32'h400);
      check("t4_pop1", pop_pc_at(1), 32'h404);
      check("t4_drop20c", 32'(find_pop(32'h20C)), 32'hFFFF_FFFF);

      // Access fault on 0x208; fetch carries on.
      bad_addr = 32'h208;
      do_reset(1'b1);
      run(10);
      check("t5_acc3", acc_at(3), 32'h20C);
      idx = find_pop(32'h208);
      check("t5_found208", 32'(idx >= 0), 32'd1);
      if (idx >= 0) begin
         check("t5_nop", pop_log[idx].inst, NOP);
         check("t5_bad", 32'(pop_log[idx].bad), 32'd1);
      end
      idx = find_pop(32'h20C);
      check("t5_found20c", 32'(idx >= 0), 32'd1);
      if (idx >= 0) begin
         check("t5_20c_inst", pop_log[idx].inst, 32'hFDF3_020C);
         check("t5_20c_bad", 32'(pop_log[idx].bad), 32'd0);
      end
      bad_addr = 32'hFFFF_FFFF;

      // Asynchronous reset with a full queue.
      do_reset(1'b0);
      run(8);
      check("t6_full_valid", 32'(inst_valid), 32'd1);
      #1;
      reset_n = 1'b0;
      #1;
      check("t6_req_valid", 32'(imem_req_valid), 32'd1);
      check("t6_addr", imem_addr, 32'h200);
      check("t6_inst_valid", 32'(inst_valid), 32'd0);
      check("t6_inst", inst, NOP);
      check("t6_inst_pc", inst_pc, 32'h0);
      check("t6_badmem", 32'(inst_badmem), 32'd0);
      do_reset(1'b1);
      run(4);
      check("t6_restart0", acc_at(0), 32'h200);
      check("t6_restart1", acc_at(1), 32'h204);
      check("t6_pop0", pop_pc_at(0), 32'h200);

      $display("TB_RESULT checks=%0d failures=%0d",
               checks, failures);
      $finish;
   end

endmodule
